// File: rtl/cryptoveril_pipe.sv
// Iterative add-rotate-xor block cipher with valid/ready handshakes.
// One round step (xor, rotate, add) executes per clock; ROUNDS rounds per word.
module cryptoveril_pipe #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned KEY_W  = 5,
   parameter int unsigned ROUNDS = 3
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              mode,
   input  logic              key_ld,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int unsigned      CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam int unsigned      SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_R = CNT_W'(ROUNDS - 1);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

   state_t            state;
   logic [KEY_W-1:0]  key_q;
   logic [KEY_W-1:0]  op_key;
   logic [KEY_W-1:0]  rk;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] k_exp;
   logic [DATA_W-1:0] rot_l;
   logic [DATA_W-1:0] rot_r;
   logic [DATA_W-1:0] s3_val;
   logic [SH_W-1:0]   sh;
   logic              dec;
   logic              last_round;

   // Round key and its bitwise expansion to the datapath width
   assign rk = op_key + KEY_W'(cnt);

   for (genvar g = 0; g < int'(DATA_W); g++) begin : g_exp
      assign k_exp[g] = rk[g % KEY_W];
   end

   assign sh         = SH_W'(32'(rk) % DATA_W);
   assign rot_l      = (x << sh) | (x >> (DATA_W - 32'(sh)));
   assign rot_r      = (x >> sh) | (x << (DATA_W - 32'(sh)));
   assign s3_val     = dec ? (x ^ k_exp) : (x + k_exp);
   assign last_round = dec ? (cnt == '0) : (cnt == LAST_R);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key_q     <= '0;
         op_key    <= '0;
         cnt       <= '0;
         x         <= '0;
         dec       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         // The key register follows key_ld at all times; the operation uses op_key
         if (key_ld) key_q <= key_in;

         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  x        <= in_data;
                  dec      <= mode;
                  op_key   <= key_ld ? key_in : key_q;
                  cnt      <= mode ? LAST_R : '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S1;
               end
            end
            S1: begin
               x     <= dec ? (x - k_exp) : (x ^ k_exp);
               state <= S2;
            end
            S2: begin
               x     <= dec ? rot_r : rot_l;
               state <= S3;
            end
            S3: begin
               x <= s3_val;
               if (last_round) begin
                  out_data  <= s3_val;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt   <= dec ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
                  state <= S1;
               end
            end
            DONE: begin
               // Release returns to IDLE with in_ready already high for the next cycle
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cryptoveril_pipe.sv
// Bench for cryptoveril_pipe: a ROUNDS=1 instance for fixed vectors and a
// default instance for random round trips, backpressure and reset abort.
module tb_cryptoveril_pipe;

   localparam int unsigned DW = 16;
   localparam int unsigned KW = 5;
   localparam int unsigned RD = 3;

   logic clk1;
   logic rst;

   logic          r1_mode, r1_key_ld, r1_in_valid, r1_in_ready;
   logic          r1_out_valid, r1_out_ready, r1_busy;
   logic [KW-1:0] r1_key_in;
   logic [DW-1:0] r1_in_data, r1_out_data;

   logic          d_mode, d_key_ld, d_in_valid, d_in_ready;
   logic          d_out_valid, d_out_ready, d_busy;
   logic [KW-1:0] d_key_in;
   logic [DW-1:0] d_in_data, d_out_data;

   int n_cmp;
   int n_bad;

   cryptoveril_pipe #(.DATA_W(DW), .KEY_W(KW), .ROUNDS(1)) u_r1 (
      .clk1(clk1), .rst(rst), .mode(r1_mode), .key_ld(r1_key_ld), .key_in(r1_key_in),
      .in_valid(r1_in_valid), .in_ready(r1_in_ready), .in_data(r1_in_data),
      .out_valid(r1_out_valid), .out_ready(r1_out_ready), .out_data(r1_out_data),
      .busy(r1_busy)
   );

   cryptoveril_pipe #(.DATA_W(DW), .KEY_W(KW), .ROUNDS(RD)) u_dut (
      .clk1(clk1), .rst(rst), .mode(d_mode), .key_ld(d_key_ld), .key_in(d_key_in),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
      .busy(d_busy)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   // Reference model: the cipher written as plain loops over rounds
   function automatic logic [DW-1:0] expand(input int rk);
      logic [DW-1:0] k;
      for (int i = 0; i < int'(DW); i++) k[i] = rk[i % int'(KW)];
      return k;
   endfunction

   function automatic logic [DW-1:0] cipher(input logic [DW-1:0] v, input int key,
                                            input bit dec, input int rounds);
      logic [DW-1:0] k;
      int rk;
      if (!dec) begin
         for (int r = 0; r < rounds; r++) begin
            rk = (key + r) % 32;
            k  = expand(rk);
            v  = v ^ k;
            for (int i = 0; i < rk % 16; i++) v = {v[DW-2:0], v[DW-1]};
            v  = v + k;
         end
      end else begin
         for (int r = rounds - 1; r >= 0; r--) begin
            rk = (key + r) % 32;
            k  = expand(rk);
            v  = v - k;
            for (int i = 0; i < rk % 16; i++) v = {v[0], v[DW-1:1]};
            v  = v ^ k;
         end
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic get_ir(input bit sel);
      return sel ? r1_in_ready : d_in_ready;
   endfunction

   function automatic logic get_ov(input bit sel);
      return sel ? r1_out_valid : d_out_valid;
   endfunction

   function automatic logic [DW-1:0] get_od(input bit sel);
      return sel ? r1_out_data : d_out_data;
   endfunction

   task automatic set_in(input bit sel, input logic v, input logic [DW-1:0] data,
                         input logic md, input logic ld, input logic [KW-1:0] k);
      if (sel) begin
         r1_in_valid = v; r1_in_data = data; r1_mode = md; r1_key_ld = ld; r1_key_in = k;
      end else begin
         d_in_valid = v; d_in_data = data; d_mode = md; d_key_ld = ld; d_key_in = k;
      end
   endtask

   task automatic set_key(input bit sel, input logic ld, input logic [KW-1:0] k);
      if (sel) begin r1_key_ld = ld; r1_key_in = k; end
      else begin d_key_ld = ld; d_key_in = k; end
   endtask

   task automatic set_ordy(input bit sel, input logic v);
      if (sel) r1_out_ready = v;
      else d_out_ready = v;
   endtask

   task automatic load_key(input bit sel, input logic [KW-1:0] k);
      set_key(sel, 1'b1, k);
      @(negedge clk1);
      set_key(sel, 1'b0, k);
   endtask

   // One word through a DUT; optionally pulses key_ld with kb_val while busy
   task automatic run_op(input bit sel, input logic [DW-1:0] data, input logic [KW-1:0] key,
                         input logic md, input logic ld, input bit kb_en,
                         input logic [KW-1:0] kb_val, output logic [DW-1:0] res,
                         output int lat);
      int n;
      n = 0;
      while (!get_ir(sel) && n < 100) begin @(negedge clk1); n++; end
      if (n >= 100) chk("in_ready_timeout", 32'(get_ir(sel)), 32'd1);
      set_in(sel, 1'b1, data, md, ld, key);
      @(negedge clk1);
      set_in(sel, 1'b0, '0, 1'b0, 1'b0, key);
      lat = 0;
      while (!get_ov(sel) && lat < 200) begin
         set_key(sel, kb_en && lat == 1, kb_val);
         @(negedge clk1);
         lat++;
      end
      set_key(sel, 1'b0, kb_val);
      res = get_od(sel);
      set_ordy(sel, 1'b1);
      @(negedge clk1);
      set_ordy(sel, 1'b0);
   endtask

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] key;
      logic          md;
      logic          ld;
      logic [DW-1:0] exp;
   } vec_t;

   initial begin
      vec_t          tbl[6];
      logic [DW-1:0] res, res2, x, xb, expv;
      logic [KW-1:0] key;
      logic          ld;
      logic          saw;
      int            lat;

      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      set_in(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      r1_out_ready = 1'b0;
      d_out_ready  = 1'b0;

      tbl[0] = '{16'h0001, 5'd6,  1'b0, 1'b0, 16'h4A8C};
      tbl[1] = '{16'h4A8C, 5'd6,  1'b1, 1'b0, 16'h0001};
      tbl[2] = '{16'hBEEF, 5'd0,  1'b0, 1'b1, 16'hBEEF};
      tbl[3] = '{16'hBEEF, 5'd0,  1'b1, 1'b0, 16'hBEEF};
      tbl[4] = '{16'hFFFF, 5'd31, 1'b0, 1'b1, 16'hFFFF};
      tbl[5] = '{16'h0001, 5'd6,  1'b0, 1'b1, 16'h4A8C};

      // Reset values and in_ready rising on the first edge after release
      #2;
      chk("rst_in_ready",  32'(d_in_ready),  32'd0);
      chk("rst_out_valid", 32'(d_out_valid), 32'd0);
      chk("rst_busy",      32'(d_busy),      32'd0);
      chk("rst_out_data",  32'(d_out_data),  32'd0);
      chk("rst_r1_ready",  32'(r1_in_ready), 32'd0);
      @(negedge clk1);
      rst = 1'b0;
      #1;
      chk("post_rst_ready_low", 32'(d_in_ready), 32'd0);
      @(negedge clk1);
      chk("post_rst_ready_high",    32'(d_in_ready),  32'd1);
      chk("post_rst_r1_ready_high", 32'(r1_in_ready), 32'd1);

      // Fixed vectors on the single-round instance
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].ld) load_key(1'b1, tbl[i].key ^ 5'h0A);
         else load_key(1'b1, tbl[i].key);
         run_op(1'b1, tbl[i].data, tbl[i].key, tbl[i].md, tbl[i].ld, 1'b0, '0, res, lat);
         chk($sformatf("vec%0d_data", i), 32'(res), 32'(tbl[i].exp));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      end

      // Random round trips with default parameters
      for (int i = 0; i < 1000; i++) begin
         x   = DW'($urandom);
         key = KW'($urandom_range(0, 31));
         ld  = 1'($urandom_range(0, 1));
         if (!ld) load_key(1'b0, key);
         run_op(1'b0, x, key, 1'b0, ld, 1'b0, '0, res, lat);
         chk("rand_enc", 32'(res), 32'(cipher(x, int'(key), 1'b0, RD)));
         chk("rand_enc_lat", 32'(lat), 32'd9);
         run_op(1'b0, res, key, 1'b1, 1'b0, 1'b0, '0, res2, lat);
         chk("rand_dec", 32'(res2), 32'(x));
         chk("rand_dec_lat", 32'(lat), 32'd9);
      end

      // key_ld while busy changes only the key register
      run_op(1'b0, 16'h3C5A, 5'd7, 1'b0, 1'b1, 1'b1, 5'd22, res, lat);
      chk("busy_key_enc", 32'(res), 32'(cipher(16'h3C5A, 7, 1'b0, RD)));
      run_op(1'b0, res, 5'd0, 1'b1, 1'b0, 1'b0, '0, res2, lat);
      chk("busy_key_reg", 32'(res2), 32'(cipher(res, 22, 1'b1, RD)));

      // Backpressure: 20 stalled cycles with a second word offered
      load_key(1'b0, 5'd19);
      x  = 16'h1234;
      xb = 16'hAAAA;
      set_in(1'b0, 1'b1, x, 1'b0, 1'b0, 5'd19);
      @(negedge clk1);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd19);
      lat = 0;
      while (!d_out_valid && lat < 200) begin @(negedge clk1); lat++; end
      chk("bp_lat", 32'(lat), 32'd9);
      expv = cipher(x, 19, 1'b0, RD);
      set_in(1'b0, 1'b1, xb, 1'b0, 1'b0, 5'd19);
      for (int i = 0; i < 20; i++) begin
         chk("bp_data",      32'(d_out_data),  32'(expv));
         chk("bp_out_valid", 32'(d_out_valid), 32'd1);
         chk("bp_in_ready",  32'(d_in_ready),  32'd0);
         @(negedge clk1);
      end
      d_out_ready = 1'b1;
      @(negedge clk1);
      d_out_ready = 1'b0;
      chk("rel_in_ready",  32'(d_in_ready),  32'd1);
      chk("rel_out_valid", 32'(d_out_valid), 32'd0);
      chk("rel_busy",      32'(d_busy),      32'd0);
      @(negedge clk1);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd19);
      chk("second_accept_busy", 32'(d_busy), 32'd1);
      lat = 0;
      while (!d_out_valid && lat < 200) begin @(negedge clk1); lat++; end
      chk("second_lat",  32'(lat), 32'd9);
      chk("second_data", 32'(d_out_data), 32'(cipher(xb, 19, 1'b0, RD)));
      d_out_ready = 1'b1;
      @(negedge clk1);
      d_out_ready = 1'b0;

      // Reset pulse in S2 of round 1 aborts the word
      set_in(1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0, 5'd19);
      @(negedge clk1);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd0);
      repeat (4) @(negedge clk1);
      chk("pre_abort_busy", 32'(d_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_in_ready",  32'(d_in_ready),  32'd0);
      chk("abort_out_valid", 32'(d_out_valid), 32'd0);
      chk("abort_busy",      32'(d_busy),      32'd0);
      chk("abort_out_data",  32'(d_out_data),  32'd0);
      @(negedge clk1);
      rst = 1'b0;
      @(negedge clk1);
      chk("abort_rel_ready", 32'(d_in_ready), 32'd1);
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk1);
         if (d_out_valid) saw = 1'b1;
      end
      chk("abort_no_out_valid", 32'(saw), 32'd0);
      run_op(1'b0, 16'hC3C3, 5'd0, 1'b0, 1'b0, 1'b0, '0, res, lat);
      chk("abort_next_data", 32'(res), 32'(cipher(16'hC3C3, 0, 1'b0, RD)));
      chk("abort_next_lat",  32'(lat), 32'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cryptoveril_pipe.md
CRYPTOVERIL_PIPE -- requirements
Module: cryptoveril_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath width; the value SHALL be at least 8.
REQ-002 Parameter KEY_W, default 5, key width; the value SHALL be at least 1 and less than DATA_W.
REQ-003 Parameter ROUNDS, default 3, number of cipher rounds; the value SHALL be at least 1.
REQ-004 One clock; reset is asynchronous and active-high: port clk1, input, 1 bit, sole clock, rising edge.
REQ-005 rst, input, 1 bit, asynchronous active-high reset.
REQ-006 mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled at accept.
REQ-007 key_ld, input, 1 bit: loads key_in into the key register.
REQ-008 key_in, input, KEY_W bits: key value.
REQ-009 in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 in_ready, output, 1 bit: the block can accept a word.
REQ-011 in_data, input, DATA_W bits: plaintext or ciphertext word.
REQ-012 out_valid, output, 1 bit: out_data holds a result.
REQ-013 out_ready, input, 1 bit: the consumer takes the result.
REQ-014 out_data, output, DATA_W bits: result word.
REQ-015 busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; at accept, the block SHALL capture in_data, mode and the key.
REQ-017 If key_ld=1 coincides with accept, the captured key SHALL be key_in; otherwise it SHALL be the key register.
REQ-018 key_ld while busy SHALL update the key register only; the in-flight operation SHALL keep its captured key.
REQ-019 Round key: rk(r) = (key + r) mod 2^KEY_W, for r = 0..ROUNDS-1. Expansion: K(r) is DATA_W bits, with K[i] = rk[i mod KEY_W].
REQ-020 Encrypt SHALL run rounds r = 0 up to ROUNDS-1, one cycle per step: S1 x^=K; S2 x=rotl(x, rk mod DATA_W); S3 x=(x+K) mod 2^DATA_W.
REQ-021 Decrypt SHALL run rounds r = ROUNDS-1 down to 0: S1 x=(x-K) mod 2^DATA_W; S2 x=rotr(x, rk mod DATA_W); S3 x^=K.
REQ-022 States: IDLE -> S1 -> S2 -> S3; after S3, go to S1 if rounds remain, else DONE; DONE -> IDLE on out_valid & out_ready.
REQ-023 Latency: with accept at edge N, out_valid SHALL rise after edge N+3*ROUNDS.
REQ-024 in_ready SHALL equal 1 only in IDLE; there SHALL be no accept in the same cycle as the out handshake; the next accept is possible one cycle after release.
REQ-025 out_valid SHALL equal 1 only in DONE; out_data SHALL stay stable while out_valid=1 and out_ready=0, with no limit on backpressure duration.
REQ-026 out_ready while not in DONE SHALL be ignored.
REQ-027 decrypt(encrypt(x, key), key) SHALL equal x for every x, key and legal parameter set.
REQ-028 The round counter SHALL wrap only through IDLE; there SHALL be no overflow for ROUNDS up to 2^16-1.

Reset
REQ-029 On rst=1, outputs SHALL immediately become in_ready=0, out_valid=0, busy=0, out_data=0; state SHALL be IDLE, and the key register and round counter SHALL be 0.
REQ-030 in_ready SHALL rise on the first clk1 edge after rst is deasserted.
REQ-031 rst mid-operation or in DONE SHALL abort: the pending result is discarded and no out_valid is produced.

Verification
REQ-032 Encrypt vector: DATA_W=16, KEY_W=5, ROUNDS=1, key 6, in_data 0x0001, mode 0 -> out_data 0x4A8C, out_valid 3 cycles after accept.
REQ-033 Decrypt vector: same parameters, in_data 0x4A8C, mode 1 -> out_data 0x0001.
REQ-034 Key-zero vector: ROUNDS=1, key 0, in_data 0xBEEF, encrypt -> out_data 0xBEEF.
REQ-035 Default parameters, random 1000 words and keys: encrypt then decrypt -> original word; latency 9 cycles each.
REQ-036 Backpressure: out_ready held 0 for 20 cycles -> out_data stable, in_ready=0, and a second in_valid is not accepted; after release -> in_ready=1 next cycle.
REQ-037 rst pulsed in S2 of round 1 -> out_valid never asserts for that word, in_ready=1 after release, and the next word produces the correct result with key 0.
